// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
//  Shared types and register-map helpers for the multi-channel PWM generator.
//  - pwm_mode_e : counter alignment mode (edge-aligned or center-aligned)
//  - addr_top   : register address of the TOP (period) shadow register
//  - addr_mode  : register address of the alignment-mode shadow register
//  Duty registers occupy addresses 0..CHANNELS-1; TOP and mode follow them.
// ----------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  function automatic int unsigned addr_top(input int unsigned channels);
    return channels;
  endfunction

  function automatic int unsigned addr_mode(input int unsigned channels);
    return channels + 1;
  endfunction

endpackage

// File: rtl/pwm_multi_gen_timebase.sv
// ----------------------------------------------------------------------------
// pwm_multi_gen_timebase
//  Shared PWM timebase: prescaler, edge/center counter and boundary detect.
//  Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run enable; low holds prescaler/counter at 0, direction up
//   prescale      counter advances once every prescale+1 clk cycles (live)
//   top           active period limit
//   mode          active alignment mode
//   cnt_next      counter value that will be registered on this edge
//   boundary      high on the cycle whose edge returns the counter to 0
//   period_tick   registered copy of boundary (aligned with cnt == 0)
// ----------------------------------------------------------------------------
module pwm_multi_gen_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      top,
  input  pwm_mode_e             mode,
  output logic [WIDTH-1:0]      cnt_next,
  output logic                  boundary,
  output logic                  period_tick
);

  logic [PRESCALE_W-1:0] presc;
  logic                  tick_q;
  logic [WIDTH-1:0]      cnt;
  logic                  dir_down;
  logic                  dir_next;

  // tick_q is registered, so the counter first moves prescale+1 cycles after
  // en rises and the first enabled cycle always presents cnt == 0.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir_down;
    boundary = 1'b0;
    if (!en) begin
      cnt_next = '0;
      dir_next = 1'b0;
    end else if (tick_q) begin
      if (mode == MODE_EDGE) begin
        if (cnt >= top) begin
          cnt_next = '0;
          dir_next = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else if (!dir_down) begin
        if (cnt >= top) begin
          if (top == '0) begin
            // Degenerate center period: counter parks at 0, every tick wraps.
            cnt_next = '0;
            boundary = 1'b1;
          end else begin
            cnt_next = cnt - 1'b1;
            dir_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else begin
        if (cnt <= 1) begin
          cnt_next = '0;
          dir_next = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      presc       <= '0;
      tick_q      <= 1'b0;
      cnt         <= '0;
      dir_down    <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      // >= keeps the prescaler from running the full range when prescale is
      // lowered below the current count.
      if (presc >= prescale) begin
        presc  <= '0;
        tick_q <= 1'b1;
      end else begin
        presc  <= presc + 1'b1;
        tick_q <= 1'b0;
      end
      cnt         <= cnt_next;
      dir_down    <= dir_next;
      period_tick <= boundary;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// ----------------------------------------------------------------------------
// pwm_multi_gen
//  Multi-channel PWM generator with one shared prescaled timebase and
//  double-buffered duty/TOP/mode registers that commit at period boundaries.
//  Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run enable; 0 = timebase held, outputs low
//   prescale      timebase ticks every prescale+1 clk cycles
//   wr_en         shadow register write strobe
//   wr_addr       0..CHANNELS-1 duty[n]; CHANNELS TOP; CHANNELS+1 mode
//   wr_data       write data (mode uses bit 0: 0 edge, 1 center)
//   pwm_out       registered PWM outputs
//   period_tick   one-cycle pulse at each period boundary
// ----------------------------------------------------------------------------
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [PRESCALE_W-1:0]         prescale,
  input  logic                          wr_en,
  input  logic [$clog2(CHANNELS+2)-1:0] wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic                          period_tick
);

  localparam int unsigned AW = $clog2(CHANNELS + 2);
  localparam logic [AW-1:0] ADDR_TOP  = AW'(addr_top(CHANNELS));
  localparam logic [AW-1:0] ADDR_MODE = AW'(addr_mode(CHANNELS));

  logic [WIDTH-1:0] duty_sh  [CHANNELS];
  logic [WIDTH-1:0] duty_act [CHANNELS];
  logic [WIDTH-1:0] top_sh;
  logic [WIDTH-1:0] top_act;
  pwm_mode_e        mode_sh;
  pwm_mode_e        mode_act;

  logic [WIDTH-1:0]    cnt_next;
  logic                boundary;
  logic                commit;
  logic [CHANNELS-1:0] pwm_d;

  // While disabled the active bank tracks the shadow bank continuously.
  assign commit = boundary | ~en;

  pwm_multi_gen_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescale    (prescale),
    .top         (top_act),
    .mode        (mode_act),
    .cnt_next    (cnt_next),
    .boundary    (boundary),
    .period_tick (period_tick)
  );

  // Active bank loads the pre-write shadow value on commit; a write landing
  // on a boundary therefore waits for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
      top_sh   <= '1;
      top_act  <= '1;
      mode_sh  <= MODE_EDGE;
      mode_act <= MODE_EDGE;
    end else begin
      if (wr_en) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (wr_addr == AW'(i)) duty_sh[i] <= wr_data;
        end
        if (wr_addr == ADDR_TOP)  top_sh  <= wr_data;
        if (wr_addr == ADDR_MODE) mode_sh <= pwm_mode_e'(wr_data[0]);
      end
      if (commit) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          duty_act[i] <= duty_sh[i];
        end
        top_act  <= top_sh;
        mode_act <= mode_sh;
      end
    end
  end

  // Compare against the duty that will be active alongside cnt_next, so the
  // new duty takes effect on exactly the cycle period_tick rises.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
    assign pwm_d[g] = en & (cnt_next < (commit ? duty_sh[g] : duty_act[g]));
  end

  always_ff @(posedge clk) begin
    if (rst) pwm_out <= '0;
    else     pwm_out <= pwm_d;
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
module tb_pwm_multi_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] prescale;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pwm_out;
  logic       period_tick;

  int checks = 0;
  int errors = 0;

  pwm_multi_gen #(
    .WIDTH      (8),
    .CHANNELS   (4),
    .PRESCALE_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescale    (prescale),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    prescale = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One idle cycle so the active bank picks up the shadow, then enable.
  task automatic start_run();
    step();
    en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pwm_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pwm got %b exp 0000", pwm_out);
    end
    checks++;
    if (period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick got %b exp 0", period_tick);
    end
  endtask

  task automatic test_edge();
    logic ep, et;
    do_reset();
    wr(3'd4, 8'd9);
    wr(3'd0, 8'd3);
    start_run();
    for (int k = 0; k < 30; k++) begin
      step();
      ep = ((k % 10) < 3);
      et = (k != 0) && ((k % 10) == 0);
      checks++;
      if (pwm_out[0] !== ep) begin
        errors++;
        $display("FAIL edge_pwm0 k=%0d got %b exp %b", k, pwm_out[0], ep);
      end
      checks++;
      if (period_tick !== et) begin
        errors++;
        $display("FAIL edge_tick k=%0d got %b exp %b", k, period_tick, et);
      end
    end
  endtask

  // Continues from test_edge: write mid-period at k=33, and on a boundary at k=50.
  task automatic test_shadow_update();
    logic ep, et;
    int duty;
    for (int k = 30; k < 70; k++) begin
      if (k == 33 || k == 50) begin
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = (k == 33) ? 8'd7 : 8'd5;
      end
      step();
      wr_en = 1'b0;
      duty = (k >= 60) ? 5 : (k >= 40) ? 7 : 3;
      ep = ((k % 10) < duty);
      et = ((k % 10) == 0);
      checks++;
      if (pwm_out[0] !== ep) begin
        errors++;
        $display("FAIL shadow_pwm0 k=%0d got %b exp %b", k, pwm_out[0], ep);
      end
      checks++;
      if (period_tick !== et) begin
        errors++;
        $display("FAIL shadow_tick k=%0d got %b exp %b", k, period_tick, et);
      end
    end
  endtask

  task automatic test_constant();
    do_reset();
    wr(3'd4, 8'd9);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd200);
    wr(3'd0, 8'd3);
    start_run();
    for (int k = 0; k < 50; k++) begin
      step();
      checks++;
      if (pwm_out[3:1] !== 3'b010) begin
        errors++;
        $display("FAIL const_pwm321 k=%0d got %b exp 010", k, pwm_out[3:1]);
      end
    end
  endtask

  task automatic test_center();
    logic [7:0] pat;
    logic ep, et;
    int highs;
    pat   = 8'b1000_0011;  // cnt sequence 0,1,2,3,4,3,2,1 with duty 2
    highs = 0;
    do_reset();
    wr(3'd4, 8'd4);
    wr(3'd5, 8'd1);
    wr(3'd0, 8'd2);
    start_run();
    for (int k = 0; k < 24; k++) begin
      step();
      ep = pat[k % 8];
      et = (k != 0) && ((k % 8) == 0);
      if (k < 8 && pwm_out[0] === 1'b1) highs++;
      checks++;
      if (pwm_out[0] !== ep) begin
        errors++;
        $display("FAIL center_pwm0 k=%0d got %b exp %b", k, pwm_out[0], ep);
      end
      checks++;
      if (period_tick !== et) begin
        errors++;
        $display("FAIL center_tick k=%0d got %b exp %b", k, period_tick, et);
      end
    end
    checks++;
    if (highs != 3) begin
      errors++;
      $display("FAIL center_high_count got %0d exp 3", highs);
    end
  endtask

  task automatic test_prescale();
    logic ep, et;
    do_reset();
    prescale = 8'd3;
    wr(3'd4, 8'd1);
    wr(3'd0, 8'd1);
    start_run();
    for (int k = 0; k < 34; k++) begin
      if (k == 24) prescale = 8'd0;
      step();
      if (k < 24) begin
        ep = (((k / 4) % 2) == 0);
        et = (k != 0) && ((k % 8) == 0);
      end else begin
        ep = (((k - 24) % 2) == 0);
        et = ep;
      end
      checks++;
      if (pwm_out[0] !== ep) begin
        errors++;
        $display("FAIL presc_pwm0 k=%0d got %b exp %b", k, pwm_out[0], ep);
      end
      checks++;
      if (period_tick !== et) begin
        errors++;
        $display("FAIL presc_tick k=%0d got %b exp %b", k, period_tick, et);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic ep, et;
    do_reset();
    wr(3'd4, 8'd9);
    wr(3'd0, 8'd3);
    start_run();
    for (int k = 0; k < 11; k++) step();
    wr(3'd0, 8'd8);
    wr(3'd5, 8'd1);
    // reset coincides with a write and en; reset must win
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd1;
    wr_data = 8'd9;
    step();
    checks++;
    if (pwm_out !== 4'b0000) begin
      errors++;
      $display("FAIL rst_pwm got %b exp 0000", pwm_out);
    end
    checks++;
    if (period_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick got %b exp 0", period_tick);
    end
    rst   = 1'b0;
    wr_en = 1'b0;
    en    = 1'b0;
    step();
    wr(3'd0, 8'd2);
    start_run();
    // TOP back to 255, edge mode: period 256 cycles
    for (int k = 0; k < 260; k++) begin
      step();
      ep = ((k % 256) < 2);
      et = (k == 256);
      checks++;
      if (pwm_out !== {3'b000, ep}) begin
        errors++;
        $display("FAIL rst_after_pwm k=%0d got %b exp %b", k, pwm_out, {3'b000, ep});
      end
      checks++;
      if (period_tick !== et) begin
        errors++;
        $display("FAIL rst_after_tick k=%0d got %b exp %b", k, period_tick, et);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (pwm_out !== 4'b0000) begin
      errors++;
      $display("FAIL en_drop_pwm got %b exp 0000", pwm_out);
    end
    checks++;
    if (period_tick !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_tick got %b exp 0", period_tick);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      ep = (k < 2);
      checks++;
      if (pwm_out[0] !== ep) begin
        errors++;
        $display("FAIL en_restart_pwm0 k=%0d got %b exp %b", k, pwm_out[0], ep);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_shadow_update();
    test_constant();
    test_center();
    test_prescale();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
